// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

   localparam int MULDIV_DWIDTH = 32;

   typedef enum logic [2:0] {
      MULDIV_OP_MUL    = 3'b000,
      MULDIV_OP_MULH   = 3'b001,
      MULDIV_OP_MULHSU = 3'b010,
      MULDIV_OP_MULHU  = 3'b011,
      MULDIV_OP_DIV    = 3'b100,
      MULDIV_OP_DIVU   = 3'b101,
      MULDIV_OP_REM    = 3'b110,
      MULDIV_OP_REMU   = 3'b111
   } muldiv_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } muldiv_state_e;

   localparam logic [MULDIV_DWIDTH-1:0] MULDIV_INT_MIN = {1'b1, {(MULDIV_DWIDTH-1){1'b0}}};
   localparam logic [MULDIV_DWIDTH-1:0] MULDIV_DIV0_Q  = '1;
   localparam logic [MULDIV_DWIDTH-1:0] MULDIV_OVF_Q   = MULDIV_INT_MIN;
   localparam logic [MULDIV_DWIDTH-1:0] MULDIV_OVF_R   = '0;

   function automatic logic is_div(input muldiv_op_e op);
      return op[2];
   endfunction

   function automatic logic is_rem(input muldiv_op_e op);
      return op[2] & op[1];
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface muldiv_if
   import muldiv_pkg::*;
#(
   parameter int DWIDTH = MULDIV_DWIDTH
);
   logic              i_start;
   logic              i_kill;
   muldiv_op_e        i_funct3;
   logic [DWIDTH-1:0] i_op_a;
   logic [DWIDTH-1:0] i_op_b;
   logic              o_busy;
   logic              o_done;
   logic [DWIDTH-1:0] o_result;

   modport slave (
      input  i_start, i_kill, i_funct3, i_op_a, i_op_b,
      output o_busy, o_done, o_result
   );

   modport master (
      output i_start, i_kill, i_funct3, i_op_a, i_op_b,
      input  o_busy, o_done, o_result
   );
endinterface

// File: rtl/muldiv_sign_adj.sv
// Two-lane conditional two's-complement: magnitude/sign extraction at capture,
// or forced negation of the final quotient/product and remainder at fix-up.
module muldiv_sign_adj #(
   parameter int WA = 32,
   parameter int WB = 32
) (
   input  logic [WA-1:0] i_a,
   input  logic [WB-1:0] i_b,
   input  logic          i_a_signed,
   input  logic          i_b_signed,
   input  logic          i_a_force,
   input  logic          i_b_force,
   output logic [WA-1:0] o_a,
   output logic [WB-1:0] o_b,
   output logic          o_a_neg,
   output logic          o_b_neg
);
   assign o_a_neg = i_a_force | (i_a_signed & i_a[WA-1]);
   assign o_b_neg = i_b_force | (i_b_signed & i_b[WB-1]);
   assign o_a     = o_a_neg ? (~i_a + WA'(1)) : i_a;
   assign o_b     = o_b_neg ? (~i_b + WB'(1)) : i_b;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (shift-add multiply, restoring divide).
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply path.
module muldiv_unit
   import muldiv_pkg::*;
(
   input  logic     i_clk,
   input  logic     i_rst,
   muldiv_if.slave  io_bus
);
   localparam int W  = MULDIV_DWIDTH;
   localparam int CW = $clog2(W + 1);

   muldiv_state_e  r_state, w_state_next;
   muldiv_op_e     r_op;
   logic [CW-1:0]  r_count;
   logic [W-1:0]   r_opnd, r_result;
   logic [2*W-1:0] r_acc;
   logic           r_neg;

   muldiv_op_e     w_op_in, w_fix_op;
   logic           w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_neg_in, w_fix_neg;
   logic [W-1:0]   w_a_mag, w_b_mag, w_special_res, w_fix_b, w_fix_result;
   logic           w_div_zero, w_div_ovf, w_special, w_fast_mul;
   logic           w_capture, w_step, w_load_res, w_load_special;
   logic [W:0]     w_mul_sum, w_rem_shift, w_diff;
   logic [2*W-1:0] w_mul_next, w_div_next, w_acc_next, w_fix_a, w_fix_a_out;
   logic           w_fix_a_neg, w_fix_b_neg, w_unused_fix;

   assign w_op_in    = io_bus.i_funct3;
   assign w_a_signed = w_op_in inside {MULDIV_OP_MULH, MULDIV_OP_MULHSU, MULDIV_OP_DIV, MULDIV_OP_REM};
   assign w_b_signed = w_op_in inside {MULDIV_OP_MULH, MULDIV_OP_DIV, MULDIV_OP_REM};

   muldiv_sign_adj #(.WA(W), .WB(W)) u_capture (
      .i_a(io_bus.i_op_a), .i_b(io_bus.i_op_b),
      .i_a_signed(w_a_signed), .i_b_signed(w_b_signed),
      .i_a_force(1'b0), .i_b_force(1'b0),
      .o_a(w_a_mag), .o_b(w_b_mag), .o_a_neg(w_a_neg), .o_b_neg(w_b_neg)
   );

   // Remainder takes the dividend's sign; everything else the product of signs.
   assign w_neg_in   = is_rem(w_op_in) ? w_a_neg : (w_a_neg ^ w_b_neg);

   assign w_div_zero = is_div(w_op_in) && (io_bus.i_op_b == '0);
   assign w_div_ovf  = (w_op_in inside {MULDIV_OP_DIV, MULDIV_OP_REM}) &&
                       (io_bus.i_op_a == MULDIV_INT_MIN) && (io_bus.i_op_b == '1);
   assign w_special  = w_div_zero | w_div_ovf;
   assign w_special_res = w_div_zero ? (is_rem(w_op_in) ? io_bus.i_op_a : MULDIV_DIV0_Q)
                                     : (is_rem(w_op_in) ? MULDIV_OVF_R  : MULDIV_OVF_Q);

`ifdef MULDIV_FAST_MUL_EN
   assign w_fast_mul = !is_div(w_op_in);
`else
   assign w_fast_mul = 1'b0;
`endif

   // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, quotient}.
   assign w_mul_sum   = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
   assign w_mul_next  = {w_mul_sum, r_acc[W-1:1]};
   assign w_rem_shift = {r_acc[2*W-1:W], r_acc[W-1]};
   assign w_diff      = w_rem_shift - {1'b0, r_opnd};
   assign w_div_next  = w_diff[W] ? {w_rem_shift[W-1:0], r_acc[W-2:0], 1'b0}
                                  : {w_diff[W-1:0],      r_acc[W-2:0], 1'b1};
   assign w_acc_next  = is_div(r_op) ? w_div_next : w_mul_next;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      w_fix_a   = is_div(r_op) ? {{W{1'b0}}, w_acc_next[W-1:0]} : w_acc_next;
      w_fix_neg = r_neg;
      w_fix_op  = r_op;
`ifdef MULDIV_FAST_MUL_EN
      if (r_state == IDLE) begin
         w_fix_a   = {{W{1'b0}}, w_a_mag} * {{W{1'b0}}, w_b_mag};
         w_fix_neg = w_neg_in;
         w_fix_op  = w_op_in;
      end
`endif
   end

   muldiv_sign_adj #(.WA(2*W), .WB(W)) u_fixup (
      .i_a(w_fix_a), .i_b(w_acc_next[2*W-1:W]),
      .i_a_signed(1'b0), .i_b_signed(1'b0),
      .i_a_force(w_fix_neg), .i_b_force(w_fix_neg),
      .o_a(w_fix_a_out), .o_b(w_fix_b), .o_a_neg(w_fix_a_neg), .o_b_neg(w_fix_b_neg)
   );
   assign w_unused_fix = w_fix_a_neg ^ w_fix_b_neg;

   always_comb begin
      case (w_fix_op)
         MULDIV_OP_MULH, MULDIV_OP_MULHSU, MULDIV_OP_MULHU: w_fix_result = w_fix_a_out[2*W-1:W];
         MULDIV_OP_REM, MULDIV_OP_REMU:                     w_fix_result = w_fix_b;
         default:                                           w_fix_result = w_fix_a_out[W-1:0];
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next   = r_state;
      w_capture      = 1'b0;
      w_step         = 1'b0;
      w_load_res     = 1'b0;
      w_load_special = 1'b0;
      case (r_state)
         IDLE: if (io_bus.i_start && !io_bus.i_kill) begin
            w_capture = 1'b1;
            if (w_special) begin
               w_state_next   = DONE;
               w_load_special = 1'b1;
            end else if (w_fast_mul) begin
               w_state_next = DONE;
               w_load_res   = 1'b1;
            end else begin
               w_state_next = CALC;
            end
         end
         CALC: if (io_bus.i_kill) begin
            w_state_next = IDLE;
         end else begin
            w_step = 1'b1;
            if (r_count == CW'(1)) begin
               w_state_next = DONE;
               w_load_res   = 1'b1;
            end
         end
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // NOTE: datapath registers are reset too; their reset values are observable.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_op     <= MULDIV_OP_MUL;
         r_count  <= '0;
         r_opnd   <= '0;
         r_acc    <= '0;
         r_neg    <= 1'b0;
         r_result <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         if (w_capture) begin
            r_op    <= w_op_in;
            r_neg   <= w_neg_in;
            r_count <= CW'(W);
            r_opnd  <= is_div(w_op_in) ? w_b_mag : w_a_mag;
            r_acc   <= {{W{1'b0}}, is_div(w_op_in) ? w_a_mag : w_b_mag};
         end else if (w_step) begin
            r_acc   <= w_acc_next;
            r_count <= r_count - CW'(1);
         end
         if (w_load_special)  r_result <= w_special_res;
         else if (w_load_res) r_result <= w_fix_result;
      end
   end

   assign io_bus.o_busy   = (r_state != IDLE);
   assign io_bus.o_done   = (r_state == DONE);
   assign io_bus.o_result = r_result;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors push expectations, a monitor checks each Done.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int ITER_LAT = MULDIV_DWIDTH + 1;
`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = ITER_LAT;
`endif

   typedef struct {
      logic [31:0] res;
      int          lat;
      int          t0;
      string       name;
   } exp_t;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          t0;
   logic [31:0] last_res = '0;
   exp_t        q[$];

   muldiv_if bus();

   muldiv_unit dut (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .io_bus (bus)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: one scoreboard pop per Done pulse, sampled on the falling edge.
   always @(negedge i_clk) begin
      exp_t e;
      cyc++;
      if (bus.o_done === 1'b1) begin
         if (q.size() == 0) begin
            check("spurious_done", 32'(bus.o_done), 32'd0);
         end else begin
            e = q.pop_front();
            check({e.name, "_result"},  bus.o_result,       e.res);
            check({e.name, "_latency"}, 32'(cyc - e.t0),    32'(e.lat));
            check({e.name, "_busy"},    32'(bus.o_busy),    32'd1);
         end
      end
   end

   task automatic issue(input muldiv_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input int lat, input string name);
      exp_t e;
      @(negedge i_clk); #1;
      check({name, "_idle_before"}, 32'(bus.o_busy), 32'd0);
      bus.i_funct3 = op;
      bus.i_op_a   = a;
      bus.i_op_b   = b;
      bus.i_start  = 1'b1;
      e.res = res; e.lat = lat; e.t0 = cyc; e.name = name;
      q.push_back(e);
      last_res = res;
      @(negedge i_clk); #1;
      bus.i_start = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100; i++) begin
         if (q.size() == 0) break;
         @(negedge i_clk); #2;
      end
      check("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
   endtask

   task automatic run_op(input muldiv_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input int lat, input string name);
      issue(op, a, b, res, lat, name);
      drain();
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.i_start  = 1'b0;
      bus.i_kill   = 1'b0;
      bus.i_funct3 = MULDIV_OP_MUL;
      bus.i_op_a   = '0;
      bus.i_op_b   = '0;
      repeat (3) @(negedge i_clk);
      #1;
      check("reset_busy",   32'(bus.o_busy), 32'd0);
      check("reset_done",   32'(bus.o_done), 32'd0);
      check("reset_result", bus.o_result,    32'd0);
      i_rst = 1'b0;

      run_op(MULDIV_OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT,  "mulhu_max");
      run_op(MULDIV_OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, MUL_LAT,  "mul_max");
      run_op(MULDIV_OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT,  "mulh_m1m1");
      run_op(MULDIV_OP_MULH,   32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, MUL_LAT,  "mulh_min2");
      run_op(MULDIV_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT,  "mulhsu_m1max");
      run_op(MULDIV_OP_MUL,    32'd7,         32'd6,         32'd42,        MUL_LAT,  "mul_7x6");
      run_op(MULDIV_OP_MUL,    32'h1234_5678, 32'h0000_0010, 32'h2345_6780, MUL_LAT,  "mul_shift");
      run_op(MULDIV_OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, ITER_LAT, "div_m7_2");
      run_op(MULDIV_OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, ITER_LAT, "rem_m7_2");
      run_op(MULDIV_OP_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, ITER_LAT, "div_7_m2");
      run_op(MULDIV_OP_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         ITER_LAT, "rem_7_m2");
      run_op(MULDIV_OP_DIVU,   32'd100,       32'd7,         32'd14,        ITER_LAT, "divu_100_7");
      run_op(MULDIV_OP_REMU,   32'd100,       32'd7,         32'd2,         ITER_LAT, "remu_100_7");
      run_op(MULDIV_OP_DIVU,   32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, ITER_LAT, "divu_max_1");
      run_op(MULDIV_OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1,        "divu_by0");
      run_op(MULDIV_OP_REMU,   32'd5,         32'd0,         32'd5,         1,        "remu_by0");
      run_op(MULDIV_OP_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1,        "div_by0");
      run_op(MULDIV_OP_REM,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1,        "rem_by0");
      run_op(MULDIV_OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,        "div_ovf");
      run_op(MULDIV_OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,        "rem_ovf");
      run_op(MULDIV_OP_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         ITER_LAT, "divu_min_max");
      run_op(MULDIV_OP_REMU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, ITER_LAT, "remu_min_max");

      // Kill at cycle 10 of a DIVU, with a stray Start at cycle 5.
      @(negedge i_clk); #1;
      bus.i_funct3 = MULDIV_OP_DIVU; bus.i_op_a = 32'd100; bus.i_op_b = 32'd7;
      bus.i_start  = 1'b1;
      t0 = cyc;
      @(negedge i_clk); #1;
      bus.i_start = 1'b0;
      while (cyc < t0 + 5) begin @(negedge i_clk); #1; end
      bus.i_funct3 = MULDIV_OP_MUL; bus.i_op_a = 32'd3; bus.i_op_b = 32'd3;
      bus.i_start  = 1'b1;
      @(negedge i_clk); #1;
      bus.i_start = 1'b0;
      while (cyc < t0 + 10) begin @(negedge i_clk); #1; end
      check("busy_before_kill", 32'(bus.o_busy), 32'd1);
      bus.i_kill = 1'b1;
      @(negedge i_clk); #1;
      bus.i_kill = 1'b0;
      check("kill_busy",   32'(bus.o_busy), 32'd0);
      check("kill_done",   32'(bus.o_done), 32'd0);
      check("kill_result", bus.o_result,    last_res);
      repeat (40) @(negedge i_clk);
      #1;
      check("kill_stays_idle", 32'(bus.o_busy), 32'd0);
      check("kill_result_held", bus.o_result,   last_res);

      // Kill wins over Start in IDLE.
      @(negedge i_clk); #1;
      bus.i_funct3 = MULDIV_OP_DIVU; bus.i_op_a = 32'd9; bus.i_op_b = 32'd3;
      bus.i_start  = 1'b1;
      bus.i_kill   = 1'b1;
      @(negedge i_clk); #1;
      bus.i_start = 1'b0;
      bus.i_kill  = 1'b0;
      check("kill_over_start", 32'(bus.o_busy), 32'd0);

      // Asynchronous reset in the middle of a divide.
      @(negedge i_clk); #1;
      bus.i_funct3 = MULDIV_OP_DIV; bus.i_op_a = 32'd1000; bus.i_op_b = 32'd3;
      bus.i_start  = 1'b1;
      t0 = cyc;
      @(negedge i_clk); #1;
      bus.i_start = 1'b0;
      while (cyc < t0 + 15) begin @(negedge i_clk); #1; end
      check("busy_before_reset", 32'(bus.o_busy), 32'd1);
      i_rst = 1'b1;
      #1;
      check("midrst_busy",   32'(bus.o_busy), 32'd0);
      check("midrst_done",   32'(bus.o_done), 32'd0);
      check("midrst_result", bus.o_result,    32'd0);
      @(negedge i_clk); #1;
      i_rst = 1'b0;
      run_op(MULDIV_OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, MUL_LAT, "mulhsu_after_rst");
      run_op(MULDIV_OP_DIVU,   32'd42,        32'd6, 32'd7,         ITER_LAT, "divu_after_rst");

      repeat (3) @(negedge i_clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
